// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a timed req/ack
// handshake to a variable-latency data memory and a retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             mem_req,
  output logic             MemWrite,
  output logic [2:0]       MemtoReg,
  output logic [2:0]       ALUOp,
  output logic [2:0]       ALUSrc,
  output logic             EXTsign,
  output logic             RegWrite,
  output logic [2:0]       RegDst,
  output logic [2:0]       DMOp,
  output logic [2:0]       NPCOp,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsAddu, ClsSubu, ClsOri, ClsLui, ClsLw, ClsSw, ClsBeq, ClsJal, ClsJr
  } cls_e;

  state_e           state_q, state_d;
  logic [5:0]       ir_op_q, ir_op_d;
  logic [5:0]       ir_funct_q, ir_funct_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  cls_e       cls;
  logic [2:0] alu_op_c, alu_src_c;
  logic       ext_c;
  logic       done;

  // Only opcode and funct steer the sequencer; the remaining fields feed the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  always_comb begin
    cls = ClsNone;
    case (ir_op_q)
      6'h00: begin
        case (ir_funct_q)
          6'h21:   cls = ClsAddu;
          6'h23:   cls = ClsSubu;
          6'h08:   cls = ClsJr;
          default: cls = ClsNone;
        endcase
      end
      6'h0d:   cls = ClsOri;
      6'h0f:   cls = ClsLui;
      6'h23:   cls = ClsLw;
      6'h2b:   cls = ClsSw;
      6'h04:   cls = ClsBeq;
      6'h03:   cls = ClsJal;
      default: cls = ClsNone;
    endcase
  end

  always_comb begin
    alu_op_c  = 3'd0;
    alu_src_c = 3'd0;
    ext_c     = 1'b0;
    case (cls)
      ClsSubu: alu_op_c = 3'd1;
      ClsOri:  begin alu_op_c = 3'd2; alu_src_c = 3'd1; end
      ClsLui:  begin alu_op_c = 3'd3; alu_src_c = 3'd1; end
      ClsLw,
      ClsSw:   begin alu_src_c = 3'd1; ext_c = 1'b1; end
      ClsBeq:  begin alu_op_c = 3'd1; ext_c = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 3'd0;
    ALUOp      = 3'd0;
    ALUSrc     = 3'd0;
    EXTsign    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 3'd0;
    DMOp       = 3'd0;
    NPCOp      = 3'd0;
    err        = err_q;
    state_d    = state_q;
    ir_op_d    = ir_op_q;
    ir_funct_d = ir_funct_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    done       = 1'b0;

    case (state_q)
      StFetch: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        ir_op_d    = instr[31:26];
        ir_funct_d = instr[5:0];
        state_d    = StDecode;
      end
      StDecode: begin
        if (cls == ClsNone) begin
          state_d = StFetch;
          done    = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        ALUOp   = alu_op_c;
        ALUSrc  = alu_src_c;
        EXTsign = ext_c;
        case (cls)
          ClsLw, ClsSw: state_d = StMem;
          ClsBeq: begin
            pc_we   = zero;
            NPCOp   = 3'd1;
            state_d = StFetch;
            done    = 1'b1;
          end
          ClsJal: begin
            pc_we    = 1'b1;
            NPCOp    = 3'd2;
            RegWrite = 1'b1;
            RegDst   = 3'd2;
            MemtoReg = 3'd2;
            state_d  = StFetch;
            done     = 1'b1;
          end
          ClsJr: begin
            pc_we   = 1'b1;
            NPCOp   = 3'd3;
            state_d = StFetch;
            done    = 1'b1;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        ALUOp    = alu_op_c;
        ALUSrc   = alu_src_c;
        EXTsign  = ext_c;
        mem_req  = 1'b1;
        MemWrite = (cls == ClsSw);
        if (mem_ack) begin
          cnt_d = '0;
          if (cls == ClsLw) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            done    = 1'b1;
          end
        end else if (cnt_q == TLast) begin
          // Abort: the instruction is dropped without writeback or retirement.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StWb: begin
        ALUOp    = alu_op_c;
        ALUSrc   = alu_src_c;
        EXTsign  = ext_c;
        RegWrite = 1'b1;
        RegDst   = (cls == ClsAddu || cls == ClsSubu) ? 3'd1 : 3'd0;
        MemtoReg = (cls == ClsLw) ? 3'd1 : 3'd0;
        state_d  = StFetch;
        done     = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    retired_d = done ? retired_q + CNT_W'(1) : retired_q;

    if (!reset) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 3'd0;
      ALUOp    = 3'd0;
      ALUSrc   = 3'd0;
      EXTsign  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 3'd0;
      NPCOp    = 3'd0;
      err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFetch;
      ir_op_q    <= '0;
      ir_funct_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      ir_op_q    <= ir_op_d;
      ir_funct_q <= ir_funct_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      retired_q  <= retired_d;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule
